// File: rtl/regfile_sb.sv
// Scoreboarded register file: 32 x DATA_W registers with a busy bit per register and a
// combinational operand-hazard stall. Define REGFILE_BYPASS_EN to forward same-cycle writeback.
module regfile_sb #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [4:0]        issue_dst,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall
);

    localparam int NREG = 32;

    // issue_en and wb_en are single-cycle strobes with no back-pressure: each is consumed on
    // the rising edge where it is high. stall is advisory; the caller must gate its own issue.

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
            if (wb_addr != 5'd0) begin
                regs_d[wb_addr] = wb_data;
            end
        end
        // Applied after the writeback clear so a new producer to the same index keeps it busy.
        if (issue_en) begin
            busy_d[issue_dst] = 1'b1;
        end
        busy_d[0] = 1'b0;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = wb_en && (wb_addr != 5'd0) && (wb_addr == rs_addr);
    assign rt_hit  = wb_en && (wb_addr != 5'd0) && (wb_addr == rt_addr);
    assign rs_data = rs_hit ? wb_data : regs_q[rs_addr];
    assign rt_data = rt_hit ? wb_data : regs_q[rt_addr];
    assign stall   = (busy_q[rs_addr] & ~rs_hit) | (busy_q[rt_addr] & ~rt_hit);
`else
    assign rs_data = regs_q[rs_addr];
    assign rt_data = regs_q[rt_addr];
    assign stall   = busy_q[rs_addr] | busy_q[rt_addr];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: the driver pushes hand-computed {rs_data, rt_data, stall}
// into exp_q and a negedge monitor pops and compares whenever a check is flagged.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int EXP_W  = 2 * DATA_W + 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              issue_en;
    logic [4:0]        issue_dst;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              stall;

    logic              chk_req;
    logic              end_chk;
    logic [EXP_W-1:0]  exp_q[$];
    int                checks;
    int                errors;

    regfile_sb #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .stall     (stall)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: run did not reach summary within time limit");
        $fatal(1, "watchdog expired");
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (chk_req) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL underflow: check requested with empty expected queue");
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if ({rs_data, rt_data, stall} !== e) begin
                    errors = errors + 1;
                    $display("FAIL read rs=%0d rt=%0d: got rs_data=%h rt_data=%h stall=%b, expected rs_data=%h rt_data=%h stall=%b",
                             rs_addr, rt_addr, rs_data, rt_data, stall,
                             e[EXP_W-1 -: DATA_W], e[DATA_W:1], e[0]);
                end
            end
        end
        if (end_chk) begin
            checks = checks + 1;
            if (exp_q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
            end
        end
    end

    // Driver: applies one cycle of inputs shortly after the rising edge.
    task automatic step(input logic r, input logic ie, input logic [4:0] id,
                        input logic we, input logic [4:0] wa, input logic [DATA_W-1:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input logic chk,
                        input logic [DATA_W-1:0] e_rs, input logic [DATA_W-1:0] e_rt,
                        input logic e_st);
        @(posedge clk);
        #1;
        rst       = r;
        issue_en  = ie;
        issue_dst = id;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        rs_addr   = ra;
        rt_addr   = rb;
        chk_req   = chk;
        if (chk) exp_q.push_back({e_rs, e_rt, e_st});
    endtask

    // Read-only cycle with a check.
    task automatic rd(input logic [4:0] ra, input logic [4:0] rb,
                      input logic [DATA_W-1:0] e_rs, input logic [DATA_W-1:0] e_rt,
                      input logic e_st);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, '0, ra, rb, 1'b1, e_rs, e_rt, e_st);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        chk_req   = 1'b0;
        end_chk   = 1'b0;
        rst       = 1'b1;
        issue_en  = 1'b0;
        issue_dst = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        rs_addr   = '0;
        rt_addr   = '0;

        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);

        // All registers read zero after reset
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i), '0, '0, 1'b0);
        end

        // Writes to r0 ignored; write to r5 visible next cycle
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, '0, '0, 1'b0);
        rd(5'd0, 5'd0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1,
             BYP ? 32'hDEADBEEF : 32'h0, '0, 1'b0);
        rd(5'd0, 5'd5, '0, 32'hDEADBEEF, 1'b0);

        // Issue r8, then writeback resolves the hazard
        step(1'b0, 1'b1, 5'd8, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, '0, '0, 1'b0);
        rd(5'd8, 5'd0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h12345678, 5'd8, 5'd0, 1'b1,
             BYP ? 32'h12345678 : 32'h0, '0, BYP ? 1'b0 : 1'b1);
        rd(5'd8, 5'd0, 32'h12345678, '0, 1'b0);

        // Same-edge issue and writeback to r9: data written, busy stays set
        step(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd9, 1'b1,
             '0, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0);
        rd(5'd0, 5'd9, '0, 32'hA5A5A5A5, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        rd(5'd9, 5'd8, 32'hA5A5A5A5, 32'h12345678, 1'b0);

        // Issue and writeback to different indices in the same cycle
        step(1'b0, 1'b1, 5'd10, 1'b1, 5'd5, 32'h11111111, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        rd(5'd10, 5'd5, '0, 32'h11111111, 1'b1);

        // Issue honoured while stalled
        step(1'b0, 1'b1, 5'd12, 1'b0, 5'd0, '0, 5'd10, 5'd0, 1'b1, '0, '0, 1'b1);
        rd(5'd0, 5'd12, '0, '0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd10, 32'hCAFE0000, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        rd(5'd10, 5'd12, 32'hCAFE0000, '0, 1'b1);

        // Reset mid-operation with pending busy bits and competing issue/writeback
        step(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 5'd4, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        rd(5'd3, 5'd4, '0, '0, 1'b1);
        step(1'b1, 1'b1, 5'd7, 1'b1, 5'd5, 32'h0000FFFF, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        rd(5'd3, 5'd4, '0, '0, 1'b0);
        rd(5'd5, 5'd7, '0, '0, 1'b0);
        rd(5'd10, 5'd12, '0, '0, 1'b0);

        // Issue to r0 never sets busy
        step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, '0, '0, 1'b0);
        rd(5'd0, 5'd0, '0, '0, 1'b0);

        // Writeback to a non-busy register leaves it non-busy
        step(1'b0, 1'b0, 5'd0, 1'b1, 5'd20, 32'h5A5A0F0F, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        rd(5'd20, 5'd20, 32'h5A5A0F0F, 32'h5A5A0F0F, 1'b0);

        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0);
        end_chk = 1'b1;
        @(posedge clk);
        #1;
        end_chk = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
